// File: rtl/conv_weight_loader_pkg.sv
// Shared definitions for the convolution weight loader: FSM state encodings
// and the OFF/ON constants used for strobes.
package conv_weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OFF = 1'b0;
  localparam logic ON  = 1'b1;

endpackage

// File: rtl/conv_weight_loader_weight_word_assembler.sv
// Lane-indexed assembly of one filter word from narrow beats, LSB lane first.
// word_next_o is the stored word with the current beat already merged in.
module weight_word_assembler #(
  parameter int BIT_IN   = 1024,
  parameter int BIT_WORD = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                wr,
  input  logic [BIT_WORD-1:0] data_i,
  output logic [BIT_IN-1:0]   word_next_o,
  output logic                full
);

  localparam int BEATS = BIT_IN / BIT_WORD;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [BIT_IN-1:0] word_q, word_d;
  logic [BW-1:0]     beat_q, beat_d;

  assign full = (beat_q == LAST_BEAT);

  always_comb begin
    word_next_o = word_q;
    word_next_o[beat_q*BIT_WORD +: BIT_WORD] = data_i;
  end

  always_comb begin
    word_d = word_q;
    beat_d = beat_q;
    if (clear) begin
      word_d = '0;
      beat_d = '0;
    end else if (wr) begin
      word_d = word_next_o;
      beat_d = full ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
      beat_q <= '0;
    end else begin
      word_q <= word_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/conv_weight_loader.sv
// Fills the layer's per-filter weight registers from a beat stream: assembles
// BIT_IN words and issues one registered load strobe per filter.
module conv_weight_loader
  import conv_weight_loader_pkg::*;
#(
  parameter int FILTER_OUT = 16,
  parameter int BIT_IN     = 1024,
  parameter int BIT_WORD   = 64,
  parameter int BIT_SCALE  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIT_SCALE-1:0]          cfg_scale,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [BIT_WORD-1:0]           s_data,
  input  logic                          s_last,
  output logic                          load,
  output logic [$clog2(FILTER_OUT)-1:0] addr,
  output logic [BIT_IN-1:0]             w,
  output logic [BIT_SCALE-1:0]          scale,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output state_t                        dbg_state_o
);

  localparam int AW = $clog2(FILTER_OUT);
  localparam logic [AW-1:0] LAST_F = AW'(FILTER_OUT - 1);

  // Handshake: s_ready is a registered copy of "state is FILL"; a beat
  // transfers on every rising edge where s_valid && s_ready, with no
  // combinational path from s_valid back to s_ready.
  state_t               state_q, state_d;
  logic [AW-1:0]        filt_q, filt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [BIT_IN-1:0]    w_q, w_d;
  logic [BIT_SCALE-1:0] scale_q, scale_d;
  logic                 err_q, err_d;
  logic                 s_ready_q, load_q, busy_q, done_q;

  logic              asm_clear, asm_wr, asm_full;
  logic [BIT_IN-1:0] asm_word_next;
  logic              is_final;

  weight_word_assembler #(
    .BIT_IN  (BIT_IN),
    .BIT_WORD(BIT_WORD)
  ) u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .wr         (asm_wr),
    .data_i     (s_data),
    .word_next_o(asm_word_next),
    .full       (asm_full)
  );

  assign is_final = asm_full && (filt_q == LAST_F);

  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    addr_d    = addr_q;
    w_d       = w_q;
    scale_d   = scale_q;
    err_d     = err_q;
    asm_clear = OFF;
    asm_wr    = OFF;
    case (state_q)
      IDLE: begin
        if (start) begin
          scale_d   = cfg_scale;
          filt_d    = '0;
          err_d     = OFF;
          asm_clear = ON;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (s_valid) begin
          asm_wr = ON;
          // Framing is only reported; sequencing follows the beat count.
          if (s_last != is_final) err_d = ON;
          if (asm_full) begin
            w_d     = asm_word_next;
            addr_d  = filt_q;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (filt_q == LAST_F) begin
          state_d = DONE;
        end else begin
          filt_d  = filt_q + 1'b1;
          state_d = FILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      filt_q    <= '0;
      addr_q    <= '0;
      w_q       <= '0;
      scale_q   <= '0;
      err_q     <= OFF;
      s_ready_q <= OFF;
      load_q    <= OFF;
      busy_q    <= OFF;
      done_q    <= OFF;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      addr_q    <= addr_d;
      w_q       <= w_d;
      scale_q   <= scale_d;
      err_q     <= err_d;
      s_ready_q <= (state_d == FILL);
      load_q    <= (state_d == WRITE);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign s_ready     = s_ready_q;
  assign load        = load_q;
  assign addr        = addr_q;
  assign w           = w_q;
  assign scale       = scale_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Randomized self-checking bench for conv_weight_loader with a cycle-schedule
// reference model derived from beat counts and stall positions.
module tb_conv_weight_loader;
  import conv_weight_loader_pkg::*;

  localparam int FO    = 2;
  localparam int BI    = 128;
  localparam int BWD   = 32;
  localparam int BS    = 4;
  localparam int BEATS = BI / BWD;
  localparam int TOTAL = FO * BEATS;
  localparam int AW    = 1;
  localparam int NCYC  = 128;

  logic           clock, reset, start;
  logic [BS-1:0]  cfg_scale;
  logic           s_valid, s_ready, s_last;
  logic [BWD-1:0] s_data;
  logic           load, busy, done, err;
  logic [AW-1:0]  addr;
  logic [BI-1:0]  w;
  logic [BS-1:0]  scale;
  state_t         dbg_state;

  int vectors, miscompares;

  logic [BWD-1:0] beats[TOTAL];
  bit             last_flag[TOTAL];
  bit             vld_at[NCYC];
  bit             exp_ready[NCYC];
  int             idx_at[NCYC];
  int             load_at[FO];
  int             done_at, err_from;

  conv_weight_loader #(
    .FILTER_OUT(FO), .BIT_IN(BI), .BIT_WORD(BWD), .BIT_SCALE(BS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cfg_scale(cfg_scale),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .load(load), .addr(addr), .w(w), .scale(scale), .busy(busy),
    .done(done), .err(err), .dbg_state_o(dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [BI-1:0] exp_word(input int f);
    logic [BI-1:0] r;
    for (int b = 0; b < BEATS; b++) r[b*BWD +: BWD] = beats[f*BEATS + b];
    return r;
  endfunction

  task automatic set_beats(input bit rnd);
    for (int i = 0; i < TOTAL; i++) begin
      beats[i]     = rnd ? $urandom : (i + 1);
      last_flag[i] = (i == TOTAL - 1);
    end
  endtask

  // Drives one sequence and checks every cycle against the schedule model.
  // stall_mode: 0 always valid, 1 alternate, 2 random.
  task automatic run_seq(input string name, input logic [BS-1:0] sc,
                         input int stall_mode, input int abort_k, input int start_k);
    int k, n, got, last_k, curf;
    bit exp_load;
    for (int i = 0; i < NCYC; i++) begin
      exp_ready[i] = 1'b0;
      idx_at[i]    = -1;
      case (stall_mode)
        0:       vld_at[i] = 1'b1;
        1:       vld_at[i] = (i % 2 == 1);
        default: vld_at[i] = ($urandom_range(0, 3) != 0);
      endcase
    end
    err_from = 1 << 30;
    k = 1;
    n = 0;
    for (int f = 0; f < FO; f++) begin
      got = 0;
      while (got < BEATS && k < NCYC - 16) begin
        exp_ready[k] = 1'b1;
        idx_at[k]    = n;
        if (vld_at[k]) begin
          if (last_flag[n] != (n == TOTAL - 1) && err_from > k) err_from = k + 1;
          n++;
          got++;
        end
        k++;
      end
      load_at[f] = k;
      k++;
    end
    done_at = k;

    start     = 1'b1;
    cfg_scale = sc;
    s_valid   = 1'($urandom_range(0, 1));
    s_data    = $urandom;
    s_last    = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    start = 1'b0;

    last_k = (abort_k > 0) ? abort_k : done_at + 2;
    for (k = 1; k <= last_k; k++) begin
      exp_load = 1'b0;
      curf = -1;
      for (int f = 0; f < FO; f++) begin
        if (k == load_at[f]) exp_load = 1'b1;
        if (k >= load_at[f]) curf = f;
      end
      vectors++;
      if (load !== exp_load) begin
        miscompares++;
        $display("FAIL %s load k=%0d got %0b exp %0b", name, k, load, exp_load);
      end
      if (curf >= 0) begin
        vectors++;
        if (addr !== AW'(curf) || w !== exp_word(curf)) begin
          miscompares++;
          $display("FAIL %s addr/w k=%0d got %0d/%h exp %0d/%h", name, k, addr, w, curf, exp_word(curf));
        end
      end
      vectors++;
      if (s_ready !== exp_ready[k]) begin
        miscompares++;
        $display("FAIL %s s_ready k=%0d got %0b exp %0b", name, k, s_ready, exp_ready[k]);
      end
      vectors++;
      if (busy !== (k <= done_at) || done !== (k == done_at)) begin
        miscompares++;
        $display("FAIL %s busy/done k=%0d got %0b/%0b exp %0b/%0b", name, k, busy, done, k <= done_at, k == done_at);
      end
      vectors++;
      if (scale !== sc || err !== (k >= err_from)) begin
        miscompares++;
        $display("FAIL %s scale/err k=%0d got %0d/%0b exp %0d/%0b", name, k, scale, err, sc, k >= err_from);
      end
      s_valid = vld_at[k];
      if (idx_at[k] >= 0) begin
        s_data = beats[idx_at[k]];
        s_last = last_flag[idx_at[k]];
      end else begin
        s_data = $urandom;
        s_last = 1'($urandom_range(0, 1));
      end
      start = (k == start_k);
      if (k == start_k) cfg_scale = ~sc;
      reset = (k == abort_k);
      @(posedge clock); #1;
      start = 1'b0;
      reset = 1'b0;
    end

    if (abort_k > 0) begin
      for (int c = 0; c < 12; c++) begin
        vectors++;
        if (load !== 1'b0 || addr !== '0 || w !== '0 || scale !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s post-reset c=%0d load=%0b busy=%0b ready=%0b scale=%0d got nonzero exp zero",
                   name, c, load, busy, s_ready, scale);
        end
        s_valid = 1'b1;
        s_data  = $urandom;
        s_last  = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cfg_scale = 4'hA;
    s_valid = 1'b1; s_data = '1; s_last = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (s_ready !== 1'b0 || load !== 1'b0 || addr !== '0 || w !== '0 || scale !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_values got ready=%0b load=%0b busy=%0b scale=%0d state=%0d exp all zero/IDLE",
               s_ready, load, busy, scale, dbg_state);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL idle_hold got ready=%0b busy=%0b state=%0d exp 0/0/IDLE", s_ready, busy, dbg_state);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_nominal();
    set_beats(1'b0);
    run_seq("nominal", 4'd3, 0, 0, 0);
  endtask

  task automatic test_stalls();
    set_beats(1'b0);
    run_seq("stalls", 4'd3, 1, 0, 0);
  endtask

  task automatic test_framing();
    set_beats(1'b0);
    last_flag[3] = 1'b1;
    run_seq("framing", 4'd7, 0, 0, 0);
    set_beats(1'b0);
    run_seq("framing_clear", 4'd2, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_beats(1'b0);
    run_seq("reset_mid", 4'd9, 0, 8, 0);
  endtask

  task automatic test_busy_ignore();
    set_beats(1'b1);
    run_seq("busy_ignore", 4'd5, 0, 0, 2);
  endtask

  task automatic test_reset_start_priority();
    reset = 1'b1; start = 1'b1; cfg_scale = 4'd6; s_valid = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || load !== 1'b0 || scale !== '0 || w !== '0) begin
        miscompares++;
        $display("FAIL reset_start c=%0d got busy=%0b ready=%0b load=%0b scale=%0d exp 0/0/0/0",
                 c, busy, s_ready, load, scale);
      end
      s_data = $urandom;
      @(posedge clock); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      set_beats(1'b1);
      if ($urandom_range(0, 2) == 0) last_flag[$urandom_range(0, TOTAL - 1)] ^= 1'b1;
      run_seq("random", 4'($urandom_range(0, 15)), 2, 0, 0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_nominal();
    test_stalls();
    test_framing();
    test_reset_mid();
    test_busy_ignore();
    test_reset_start_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
